// File: rtl/mips_pkg.sv
// Shared types and widths for the instruction-memory loader and its byte-to-word assembler.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int LEN_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_CSUM   = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } loader_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word shift register; word_valid pulses the cycle after the 4th byte lands.
module imem_word_assembler
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              word_last,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_data
);

   logic [1:0]               idx_q, idx_d;
   logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
   logic [WORD_W-1:0]        word_q, word_d;
   logic                     valid_q, valid_d;

   assign word_last  = byte_valid && (idx_q == 2'd3);
   assign word_valid = valid_q;
   assign word_data  = word_q;

   always_comb begin
      idx_d   = idx_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (clear) begin
         idx_d = '0;
      end else if (byte_valid) begin
         idx_d   = idx_q + 2'd1;
         shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], byte_data};
         // word_q only moves on a completed word so the write data holds between strobes
         if (idx_q == 2'd3) begin
            word_d  = {shift_q, byte_data};
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into the instruction memory write port.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CSUM state).
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [31:0] ROOM = 32'((1 << ADDR_W) - BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loader_state_e AFTER_DATA = S_CSUM;
`else
   localparam loader_state_e AFTER_DATA = S_DONE;
`endif

   loader_state_e     state_q, state_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [LEN_W-1:0]  word_idx_q, word_idx_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [LEN_W-1:0]  len_full;
   logic              start_ok, data_fire, word_last, last_word;

   assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
   assign data_fire = (state_q == S_DATA) && in_valid;
   assign len_full  = {count_q[LEN_W-1:BYTE_W], in_data};
   assign last_word = (word_idx_q == (count_q - LEN_W'(1)));
   assign mem_addr  = mem_addr_q;

   imem_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_ok),
      .byte_valid (data_fire),
      .byte_data  (in_data),
      .word_last  (word_last),
      .word_valid (mem_we),
      .word_data  (mem_wdata)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (start_ok)       csum_d = '0;
      else if (data_fire) csum_d = csum_q ^ in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) csum_q <= '0;
      else       csum_q <= csum_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         word_idx_q <= '0;
         mem_addr_q <= ADDR_W'(BASE_ADDR);
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
         S_LEN_HI: if (in_valid) state_d = S_LEN_LO;
         S_LEN_LO: begin
            if (in_valid) begin
               if (len_full == '0)                  state_d = AFTER_DATA;
               else if ({16'd0, len_full} > ROOM)   state_d = S_ERROR;
               else                                 state_d = S_DATA;
            end
         end
         // leave on the last byte; the assembler still issues that word's write next cycle
         S_DATA: if (word_last && last_word) state_d = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: if (in_valid) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d    = count_q;
      word_idx_d = word_idx_q;
      mem_addr_d = mem_addr_q;
      if (start_ok) begin
         count_d    = '0;
         word_idx_d = '0;
      end else if ((state_q == S_LEN_HI) && in_valid) begin
         count_d = {in_data, count_q[BYTE_W-1:0]};
      end else if ((state_q == S_LEN_LO) && in_valid) begin
         count_d = len_full;
      end else if (word_last) begin
         mem_addr_d = ADDR_W'(BASE_ADDR) + word_idx_q[ADDR_W-1:0];
         word_idx_d = word_idx_q + LEN_W'(1);
      end
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      unique case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_DONE:  done = 1'b1;
         S_ERROR: err  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (BASE_ADDR 0 and 1020) share one byte stream and are
// scored against a word-level model of the load rules.
module tb_imem_loader;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int BASE0  = 0;
   localparam int BASE1  = 1020;
   localparam int W      = ADDR_W + 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, start, in_valid;
   logic [7:0] in_data;

   logic in_ready0, mem_we0, busy0, done0, err0;
   logic in_ready1, mem_we1, busy1, done1, err1;
   logic [ADDR_W-1:0] mem_addr0, mem_addr1;
   logic [31:0] mem_wdata0, mem_wdata1;

   // {busy, done, err, in_ready}
   logic [3:0] flags [2];
   logic [3:0] exp_flags [2];

   int checks = 0;
   int failures = 0;

   logic [W-1:0] exp0_q[$];
   logic [W-1:0] exp1_q[$];
   logic [W-1:0] e0, e1;
   logic [7:0] data_q[$];
   logic [7:0] img_q[$];

   always #5 clk = ~clk;

   assign flags[0] = {busy0, done0, err0, in_ready0};
   assign flags[1] = {busy1, done1, err1, in_ready1};

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .busy(busy0), .done(done0), .err(err0)
   );

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .busy(busy1), .done(done1), .err(err1)
   );

   // scoreboard: every write strobe must match the head of the expected queue
   always @(negedge clk) begin
      if (mem_we0 === 1'b1) begin
         checks++;
         if (exp0_q.size() == 0) begin
            failures++;
            $display("FAIL wr0_unexpected got addr=%0d data=%h required no write", mem_addr0, mem_wdata0);
         end else begin
            e0 = exp0_q.pop_front();
            if ({mem_addr0, mem_wdata0} !== e0) begin
               failures++;
               $display("FAIL wr0 got addr=%0d data=%h required addr=%0d data=%h",
                        mem_addr0, mem_wdata0, e0[W-1:32], e0[31:0]);
            end
         end
      end
      if (mem_we1 === 1'b1) begin
         checks++;
         if (exp1_q.size() == 0) begin
            failures++;
            $display("FAIL wr1_unexpected got addr=%0d data=%h required no write", mem_addr1, mem_wdata1);
         end else begin
            e1 = exp1_q.pop_front();
            if ({mem_addr1, mem_wdata1} !== e1) begin
               failures++;
               $display("FAIL wr1 got addr=%0d data=%h required addr=%0d data=%h",
                        mem_addr1, mem_wdata1, e1[W-1:32], e1[31:0]);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   task automatic model_load(input int d, input int base, input int len, input bit bad_csum);
      logic [W-1:0] ent;
      if (len > DEPTH - base) begin
         exp_flags[d] = 4'b0010;
      end else begin
         for (int i = 0; i < len; i++) begin
            ent = {ADDR_W'(base + i), data_q[4*i], data_q[4*i+1], data_q[4*i+2], data_q[4*i+3]};
            if (d == 0) exp0_q.push_back(ent);
            else        exp1_q.push_back(ent);
         end
         exp_flags[d] = bad_csum ? 4'b0010 : 4'b0100;
      end
   endtask

   task automatic make_stream(input int len, input bit bad);
      logic [7:0]  x;
      logic [15:0] l;
      x = 8'h00;
      l = 16'(len);
      img_q.delete();
      img_q.push_back(l[15:8]);
      img_q.push_back(l[7:0]);
      if (len <= DEPTH - BASE0) begin
         foreach (data_q[i]) begin
            img_q.push_back(data_q[i]);
            x = x ^ data_q[i];
         end
         if (CSUM_ON) img_q.push_back(bad ? (x ^ 8'h01) : x);
      end
      model_load(0, BASE0, len, bad && CSUM_ON);
      model_load(1, BASE1, len, bad && CSUM_ON);
   endtask

   task automatic rand_data(input int nbytes);
      data_q.delete();
      for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // ---------------- drivers ----------------
   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // stall_mode: 0 none, 1 idle cycle before every byte, 2 random 0..3 idle cycles
   task automatic send_range(input int from, input int to, input int stall_mode);
      int n;
      for (int i = from; i < to; i++) begin
         if (stall_mode == 1) begin
            @(negedge clk); in_valid = 1'b0;
         end else if (stall_mode == 2) begin
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
            end
         end
         @(negedge clk); in_valid = 1'b1; in_data = img_q[i];
         n = 0;
         while (in_ready0 !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
         end
         checks++;
         if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout byte %0d got in_ready=%b required 1", i, in_ready0);
            in_valid = 1'b0;
            return;
         end
      end
      @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (flags[d] !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags[%0d] got %b required 0000", d, flags[d]);
         end
      end
      checks++;
      if (mem_addr0 !== ADDR_W'(BASE0) || mem_addr1 !== ADDR_W'(BASE1) || mem_wdata0 !== 32'd0) begin
         failures++;
         $display("FAIL reset_mem got addr0=%0d addr1=%0d wdata0=%h required %0d %0d 0",
                  mem_addr0, mem_addr1, mem_wdata0, BASE0, BASE1);
      end
   endtask

   task automatic test_two_words(input int stall_mode);
      data_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      make_stream(2, 1'b0);
      pulse_start();
      checks++;
      if (busy0 !== 1'b1 || in_ready0 !== 1'b1) begin
         failures++;
         $display("FAIL two_words_busy got busy=%b in_ready=%b required 1 1", busy0, in_ready0);
      end
      send_range(0, img_q.size(), stall_mode);
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (flags[d] !== exp_flags[d]) begin
            failures++;
            $display("FAIL two_words_flags[%0d] mode %0d got %b required %b", d, stall_mode, flags[d], exp_flags[d]);
         end
      end
      checks++;
      if (exp0_q.size() + exp1_q.size() != 0) begin
         failures++;
         $display("FAIL two_words_missing got %0d pending required 0", exp0_q.size() + exp1_q.size());
      end
   endtask

   task automatic test_random_loads();
      int len;
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(1, 6);
         rand_data(4 * len);
         make_stream(len, 1'b0);
         pulse_start();
         send_range(0, img_q.size(), 2);
         repeat (3) @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (flags[d] !== exp_flags[d]) begin
               failures++;
               $display("FAIL random_flags[%0d] len %0d got %b required %b", d, len, flags[d], exp_flags[d]);
            end
         end
         checks++;
         if (exp0_q.size() + exp1_q.size() != 0) begin
            failures++;
            $display("FAIL random_missing len %0d got %0d pending required 0", len, exp0_q.size() + exp1_q.size());
         end
      end
   endtask

   task automatic test_len_limits();
      int lens [4] = '{0, 1025, 4, 5};
      for (int k = 0; k < 4; k++) begin
         rand_data(lens[k] <= DEPTH ? 4 * lens[k] : 0);
         make_stream(lens[k], 1'b0);
         pulse_start();
         send_range(0, img_q.size(), 0);
         repeat (3) @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (flags[d] !== exp_flags[d]) begin
               failures++;
               $display("FAIL len_limit_flags[%0d] len %0d got %b required %b", d, lens[k], flags[d], exp_flags[d]);
            end
         end
         checks++;
         if (exp0_q.size() + exp1_q.size() != 0) begin
            failures++;
            $display("FAIL len_limit_missing len %0d got %0d pending required 0", lens[k], exp0_q.size() + exp1_q.size());
         end
      end
   endtask

   task automatic test_full_depth();
      rand_data(4 * DEPTH);
      make_stream(DEPTH, 1'b0);
      pulse_start();
      send_range(0, img_q.size(), 0);
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (flags[d] !== exp_flags[d]) begin
            failures++;
            $display("FAIL full_depth_flags[%0d] got %b required %b", d, flags[d], exp_flags[d]);
         end
      end
      checks++;
      if (exp0_q.size() + exp1_q.size() != 0) begin
         failures++;
         $display("FAIL full_depth_missing got %0d pending required 0", exp0_q.size() + exp1_q.size());
      end
   endtask

   task automatic test_reset_mid_load();
      logic [W-1:0] ent;
      rand_data(12);
      img_q.delete();
      img_q.push_back(8'h00);
      img_q.push_back(8'h03);
      for (int i = 0; i < 5; i++) img_q.push_back(data_q[i]);
      ent = {ADDR_W'(BASE0), data_q[0], data_q[1], data_q[2], data_q[3]};
      exp0_q.push_back(ent);
      ent = {ADDR_W'(BASE1), data_q[0], data_q[1], data_q[2], data_q[3]};
      exp1_q.push_back(ent);
      pulse_start();
      send_range(0, img_q.size(), 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (flags[d] !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_flags[%0d] got %b required 0000", d, flags[d]);
         end
      end
      checks++;
      if (mem_addr0 !== ADDR_W'(BASE0) || mem_addr1 !== ADDR_W'(BASE1) || mem_wdata1 !== 32'd0) begin
         failures++;
         $display("FAIL mid_reset_mem got addr0=%0d addr1=%0d wdata1=%h required %0d %0d 0",
                  mem_addr0, mem_addr1, mem_wdata1, BASE0, BASE1);
      end
      checks++;
      if (exp0_q.size() + exp1_q.size() != 0) begin
         failures++;
         $display("FAIL mid_reset_missing got %0d pending required 0", exp0_q.size() + exp1_q.size());
      end
      rand_data(8);
      make_stream(2, 1'b0);
      pulse_start();
      send_range(0, img_q.size(), 0);
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (flags[d] !== exp_flags[d]) begin
            failures++;
            $display("FAIL mid_reset_reload_flags[%0d] got %b required %b", d, flags[d], exp_flags[d]);
         end
      end
      checks++;
      if (exp0_q.size() + exp1_q.size() != 0) begin
         failures++;
         $display("FAIL mid_reset_reload_missing got %0d pending required 0", exp0_q.size() + exp1_q.size());
      end
   endtask

   task automatic test_start_while_busy();
      rand_data(12);
      make_stream(3, 1'b0);
      pulse_start();
      send_range(0, 7, 0);
      pulse_start();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (flags[d] !== 4'b1001) begin
            failures++;
            $display("FAIL start_busy_flags[%0d] got %b required 1001", d, flags[d]);
         end
      end
      send_range(7, img_q.size(), 0);
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (flags[d] !== exp_flags[d]) begin
            failures++;
            $display("FAIL start_busy_end_flags[%0d] got %b required %b", d, flags[d], exp_flags[d]);
         end
      end
      checks++;
      if (exp0_q.size() + exp1_q.size() != 0) begin
         failures++;
         $display("FAIL start_busy_missing got %0d pending required 0", exp0_q.size() + exp1_q.size());
      end
   endtask

   task automatic test_bytes_in_done();
      rand_data(4);
      make_stream(1, 1'b0);
      pulse_start();
      send_range(0, img_q.size(), 0);
      repeat (2) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         checks++;
         if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0 || done0 !== 1'b1) begin
            failures++;
            $display("FAIL done_ignore got in_ready=%b%b done0=%b required 00 1", in_ready0, in_ready1, done0);
         end
      end
      @(negedge clk); in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (exp0_q.size() + exp1_q.size() != 0) begin
         failures++;
         $display("FAIL done_ignore_missing got %0d pending required 0", exp0_q.size() + exp1_q.size());
      end
   endtask

   task automatic test_checksum();
      for (int k = 0; k < 2; k++) begin
         data_q = '{8'h12, 8'h34, 8'h56, 8'h78};
         make_stream(1, k == 1);
         pulse_start();
         send_range(0, img_q.size(), 0);
         repeat (3) @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (flags[d] !== exp_flags[d]) begin
               failures++;
               $display("FAIL csum_flags[%0d] bad=%0d got %b required %b", d, k, flags[d], exp_flags[d]);
            end
         end
         checks++;
         if (exp0_q.size() + exp1_q.size() != 0) begin
            failures++;
            $display("FAIL csum_missing bad=%0d got %0d pending required 0", k, exp0_q.size() + exp1_q.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_words(0);
      test_two_words(1);
      test_random_loads();
      test_len_limits();
      test_full_depth();
      test_reset_mid_load();
      test_start_while_busy();
      test_bytes_in_done();
      if (CSUM_ON) test_checksum();
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
